// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU fetch/execute sequencer: state codes, decode-word
// bit positions and phase values.
package cpu_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_FETCH    = 3'd1;
  localparam state_t ST_EXEC     = 3'd2;
  localparam state_t ST_MEM_WAIT = 3'd3;
  localparam state_t ST_HALT     = 3'd4;

  localparam int unsigned DEC_PC_INC = 0;
  localparam int unsigned DEC_PC_LD  = 1;
  localparam int unsigned DEC_RAM_RD = 2;
  localparam int unsigned DEC_RAM_WR = 3;
  localparam int unsigned DEC_HALT   = 4;
  localparam int unsigned DEC_W      = 5;

  localparam logic PHASE_FETCH = 1'b0;
  localparam logic PHASE_EXEC  = 1'b1;

  // PC requests and write strobe captured when a RAM access enters MEM_WAIT
  typedef struct packed {
    logic pc_ld;
    logic pc_inc;
    logic ram_we;
  } mem_req_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// 4-bit loadable down-counter timing RAM wait states; holds at zero once reached.
module seq_wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/execute sequencer for the 4-bit CPU: PC/IR strobes, RAM select with
// wait states, run/step/halt control and a retired-instruction counter.
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_clr,
  input  logic [3:0]       opcode,
  input  logic [1:0]       flags,
  input  logic             dec_pc_inc,
  input  logic             dec_pc_ld,
  input  logic             dec_ram_rd,
  input  logic             dec_ram_wr,
  input  logic             dec_halt,
  output logic [6:0]       decode_addr,
  output logic             phase,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_load,
  output logic             ram_cs,
  output logic             ram_we,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic        HAS_WAIT  = (RAM_WAIT > 0);
  localparam int unsigned WAIT_M1   = (RAM_WAIT > 0) ? RAM_WAIT - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD = WAIT_M1[3:0];

  state_t             state, state_nxt;
  logic               step_q;
  mem_req_t           req_q;
  logic [DEC_W-1:0]   dec;
  logic               step_edge, mem_acc, wait_go, wait_done, retire;

  always_comb begin
    dec             = '0;
    dec[DEC_PC_INC] = dec_pc_inc;
    dec[DEC_PC_LD]  = dec_pc_ld;
    dec[DEC_RAM_RD] = dec_ram_rd;
    dec[DEC_RAM_WR] = dec_ram_wr;
    dec[DEC_HALT]   = dec_halt;
  end

  assign step_edge = step & ~step_q;
  assign mem_acc   = dec[DEC_RAM_RD] | dec[DEC_RAM_WR];
  assign wait_go   = (state == ST_EXEC) & ~dec[DEC_HALT] & mem_acc & HAS_WAIT;
  assign retire    = ((state == ST_EXEC) & ~wait_go) | ((state == ST_MEM_WAIT) & wait_done);

  seq_wait_timer u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_go),
    .load_val (WAIT_LOAD),
    .zero     (wait_done)
  );

  always_comb begin
    state_nxt = state;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run || step_edge) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        ir_en     = 1'b1;
        pc_en     = dec[DEC_PC_INC];
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec[DEC_HALT]) begin
          state_nxt = ST_HALT;
        end else begin
          ram_cs = mem_acc;
          ram_we = dec[DEC_RAM_WR];
          if (wait_go) begin
            state_nxt = ST_MEM_WAIT;
          end else begin
            pc_load   = dec[DEC_PC_LD];
            pc_en     = dec[DEC_PC_INC] & ~dec[DEC_PC_LD];
            state_nxt = run ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_MEM_WAIT: begin
        ram_cs = 1'b1;
        ram_we = req_q.ram_we;
        if (wait_done) begin
          pc_load   = req_q.pc_ld;
          pc_en     = req_q.pc_inc & ~req_q.pc_ld;
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (halt_clr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign phase       = ((state == ST_EXEC) || (state == ST_MEM_WAIT)) ? PHASE_EXEC : PHASE_FETCH;
  assign busy        = is_busy(state);
  assign decode_addr = {opcode, flags, phase};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      step_q    <= 1'b0;
      req_q     <= '0;
      instr_cnt <= '0;
    end else begin
      state  <= state_nxt;
      step_q <= step;
      if (wait_go) begin
        req_q.pc_ld  <= dec[DEC_PC_LD];
        req_q.pc_inc <= dec[DEC_PC_INC];
        req_q.ram_we <= dec[DEC_RAM_WR];
      end
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed vector table, hand sequences and randomized
// traffic against an instruction-level reference model, on two parameterizations.
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, run, step, halt_clr;
  logic [3:0] opcode;
  logic [1:0] flags;
  logic       dec_pc_inc, dec_pc_ld, dec_ram_rd, dec_ram_wr, dec_halt;

  logic [6:0]  decode_addr_a, decode_addr_b;
  logic        phase_a, ir_en_a, pc_en_a, pc_load_a, ram_cs_a, ram_we_a, halted_a, busy_a;
  logic        phase_b, ir_en_b, pc_en_b, pc_load_b, ram_cs_b, ram_we_b, halted_b, busy_b;
  logic [15:0] instr_cnt_a;
  logic [1:0]  instr_cnt_b;
  logic [7:0]  obs_a, obs_b;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.RAM_WAIT(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_clr(halt_clr),
    .opcode(opcode), .flags(flags), .dec_pc_inc(dec_pc_inc), .dec_pc_ld(dec_pc_ld),
    .dec_ram_rd(dec_ram_rd), .dec_ram_wr(dec_ram_wr), .dec_halt(dec_halt),
    .decode_addr(decode_addr_a), .phase(phase_a), .ir_en(ir_en_a), .pc_en(pc_en_a),
    .pc_load(pc_load_a), .ram_cs(ram_cs_a), .ram_we(ram_we_a), .halted(halted_a),
    .busy(busy_a), .instr_cnt(instr_cnt_a)
  );

  cpu_seq_ctrl #(.RAM_WAIT(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_clr(halt_clr),
    .opcode(opcode), .flags(flags), .dec_pc_inc(dec_pc_inc), .dec_pc_ld(dec_pc_ld),
    .dec_ram_rd(dec_ram_rd), .dec_ram_wr(dec_ram_wr), .dec_halt(dec_halt),
    .decode_addr(decode_addr_b), .phase(phase_b), .ir_en(ir_en_b), .pc_en(pc_en_b),
    .pc_load(pc_load_b), .ram_cs(ram_cs_b), .ram_we(ram_we_b), .halted(halted_b),
    .busy(busy_b), .instr_cnt(instr_cnt_b)
  );

  // output bundle order: {phase, ir_en, pc_en, pc_load, ram_cs, ram_we, halted, busy}
  assign obs_a = {phase_a, ir_en_a, pc_en_a, pc_load_a, ram_cs_a, ram_we_a, halted_a, busy_a};
  assign obs_b = {phase_b, ir_en_b, pc_en_b, pc_load_b, ram_cs_b, ram_we_b, halted_b, busy_b};

  // Reference model: per instance, whether an instruction is in flight and how many
  // cycles into it we are (0 = fetch, 1 = exec, 2.. = wait cycles).
  int unsigned m_rw[2]  = '{3, 0};
  int unsigned m_mod[2] = '{65536, 4};
  bit          m_busy[2], m_halt[2], m_ld[2], m_inc[2], m_we[2];
  int unsigned m_k[2], m_cnt[2];
  bit          m_step_prev;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_halt[i] = 0; m_ld[i] = 0; m_inc[i] = 0; m_we[i] = 0;
      m_k[i] = 0; m_cnt[i] = 0;
    end
    m_step_prev = 0;
  endfunction

  function automatic logic [7:0] model_out(int i);
    bit ph = 0, ir = 0, pe = 0, pl = 0, cs = 0, we = 0, hl = 0, bs = 0;
    bit mem = dec_ram_rd | dec_ram_wr;
    if (m_halt[i]) hl = 1;
    else if (m_busy[i]) begin
      bs = 1;
      if (m_k[i] == 0) begin
        ir = 1; pe = dec_pc_inc;
      end else begin
        ph = 1;
        if (m_k[i] == 1) begin
          if (!dec_halt) begin
            cs = mem; we = dec_ram_wr;
            if (!(mem && m_rw[i] > 0)) begin pl = dec_pc_ld; pe = dec_pc_inc & ~dec_pc_ld; end
          end
        end else begin
          cs = 1; we = m_we[i];
          if (m_k[i] == m_rw[i] + 1) begin pl = m_ld[i]; pe = m_inc[i] & ~m_ld[i]; end
        end
      end
    end
    return {ph, ir, pe, pl, cs, we, hl, bs};
  endfunction

  function automatic void model_step();
    bit mem = dec_ram_rd | dec_ram_wr;
    for (int i = 0; i < 2; i++) begin
      if (m_halt[i]) begin
        if (halt_clr) m_halt[i] = 0;
      end else if (!m_busy[i]) begin
        if (run || (step && !m_step_prev)) begin m_busy[i] = 1; m_k[i] = 0; end
      end else if (m_k[i] == 0) begin
        m_k[i] = 1;
      end else if (m_k[i] == 1 && dec_halt) begin
        m_busy[i] = 0; m_halt[i] = 1; m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
      end else if (m_k[i] == 1 && mem && m_rw[i] > 0) begin
        m_ld[i] = dec_pc_ld; m_inc[i] = dec_pc_inc; m_we[i] = dec_ram_wr; m_k[i] = 2;
      end else if (m_k[i] == 1 || m_k[i] == m_rw[i] + 1) begin
        m_cnt[i] = (m_cnt[i] + 1) % m_mod[i]; m_busy[i] = run; m_k[i] = 0;
      end else begin
        m_k[i] = m_k[i] + 1;
      end
    end
    m_step_prev = step;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_models();
    logic [7:0] ea = model_out(0);
    logic [7:0] eb = model_out(1);
    cmp("model_a", {33'd0, obs_a, decode_addr_a, instr_cnt_a},
        {33'd0, ea, opcode, flags, ea[7], 16'(m_cnt[0])});
    cmp("model_b", {47'd0, obs_b, decode_addr_b, instr_cnt_b},
        {47'd0, eb, opcode, flags, eb[7], 2'(m_cnt[1])});
  endtask

  // dec = {halt, ram_wr, ram_rd, pc_ld, pc_inc}
  task automatic drive(input logic r, input logic rn, input logic st, input logic hc,
                       input logic [4:0] dec);
    @(negedge clk);
    reset = r; run = rn; step = st; halt_clr = hc;
    {dec_halt, dec_ram_wr, dec_ram_rd, dec_pc_ld, dec_pc_inc} = dec;
    opcode = 4'($urandom); flags = 2'($urandom);
    if (!r) model_reset();
    #1;
  endtask

  task automatic cyc(input logic r, input logic rn, input logic st, input logic hc,
                     input logic [4:0] dec);
    drive(r, rn, st, hc, dec);
    check_models();
    if (r) model_step();
  endtask

  typedef struct {
    logic        run, step, hc;
    logic [4:0]  dec;
    logic [7:0]  exp;
    int unsigned cnt;
  } vec_t;

  vec_t tbl[25];

  initial begin
    reset = 0; run = 0; step = 0; halt_clr = 0; opcode = 0; flags = 0;
    {dec_halt, dec_ram_wr, dec_ram_rd, dec_pc_ld, dec_pc_inc} = '0;
    model_reset();

    // step, jump, RAM write with 3 wait states, halt/clear, rd+wr treated as write
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 5'b00001, 8'b0000_0000, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'b00001, 8'b0110_0001, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'b00001, 8'b1010_0001, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 8'b0000_0000, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'b00010, 8'b0100_0001, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'b00011, 8'b1001_0001, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 8'b0000_0000, 2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b0000_0000, 2};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b0100_0001, 2};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'b01001, 8'b1000_1101, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b1000_1101, 2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b1000_1101, 2};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b1010_1101, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 5'b00000, 8'b0100_0001, 3};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 5'b10001, 8'b1000_0001, 3};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 5'b00000, 8'b0000_0010, 4};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b0000_0010, 4};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 5'b00000, 8'b0000_0010, 4};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b0000_0000, 4};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 5'b00000, 8'b0100_0001, 4};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 5'b01100, 8'b1000_1101, 4};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 5'b00100, 8'b1000_1101, 4};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 5'b00100, 8'b1000_1101, 4};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 5'b00101, 8'b1000_1101, 4};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 5'b00000, 8'b0000_0000, 5};

    // reset held with run=1: everything idle, decode_addr carries opcode/flags
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'b00000);
      cmp("reset_a", {33'd0, obs_a, decode_addr_a, instr_cnt_a}, {33'd0, 8'h00, opcode, flags, 1'b0, 16'h0});
      cmp("reset_b", {47'd0, obs_b, decode_addr_b, instr_cnt_b}, {47'd0, 8'h00, opcode, flags, 1'b0, 2'h0});
    end

    // free run: 10 edges after leaving IDLE retire 5; narrow counter wraps 3->0->1
    for (int j = 0; j < 12; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000);
      if (j == 9) begin
        cmp("cnt_a_4", {48'd0, instr_cnt_a}, 64'd4);
        cmp("wrap_b_0", {62'd0, instr_cnt_b}, 64'd0);
      end
      if (j == 11) begin
        cmp("cnt_a_5", {48'd0, instr_cnt_a}, 64'd5);
        cmp("wrap_b_1", {62'd0, instr_cnt_b}, 64'd1);
      end
    end

    // directed table
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, tbl[i].run, tbl[i].step, tbl[i].hc, tbl[i].dec);
      cmp($sformatf("tbl_%0d", i), {40'd0, obs_a, instr_cnt_a}, {40'd0, tbl[i].exp, 16'(tbl[i].cnt)});
      model_step();
    end

    // asynchronous reset in the middle of a RAM wait drops cs/we before any edge
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b01000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b01000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b01000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000);
    cmp("mw_entry", {62'd0, ram_cs_a, ram_we_a}, 64'd3);
    #2 reset = 1'b0;
    #1 cmp("async_rst", {62'd0, ram_cs_a, ram_we_a}, 64'd0);
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] d;
      d = 5'($urandom);
      d[4] = ($urandom_range(0, 9) == 0);
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Fetch/execute sequencer for the 4-bit CPU core.
- Drives the program counter's increment/load controls, the instruction-register latch, the phase bit into the instruction decoder, and RAM chip-select/write-enable.
- Inserts RAM wait states, handles run/single-step/halt, and counts retired instructions.

Parameters:
- RAM_WAIT, 1, extra EXEC cycles a RAM access holds cs/we (0..15); 0 means a single-cycle access.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state.
- run  in  1  level; 1 means free-running execution.
- step  in  1  when run=0, a rising edge executes exactly one instruction.
- halt_clr  in  1  leaves HALT state; level-sampled.
- opcode  in  4  upper nibble of program byte (prog_byte[7:4]).
- flags  in  2  {carry, zero} from ALU flag register.
- dec_pc_inc  in  1  decoder word: PC increment request.
- dec_pc_ld  in  1  decoder word: PC load request (jump taken).
- dec_ram_rd  in  1  decoder word: instruction reads RAM.
- dec_ram_wr  in  1  decoder word: instruction writes RAM.
- dec_halt  in  1  decoder word: halt instruction.
- decode_addr  out  7  {opcode, flags, phase} to decoder.
- phase  out  1  0 = FETCH, 1 = EXEC/MEM_WAIT.
- ir_en  out  1  instruction/operand register enable.
- pc_en  out  1  PC increment enable.
- pc_load  out  1  PC load strobe.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- halted  out  1  1 while in HALT.
- busy  out  1  1 in FETCH, EXEC or MEM_WAIT.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0): state IDLE, step edge register 0, wait counter 0, instr_cnt 0. All outputs 0 except decode_addr = {opcode, flags, 0}.
- States: IDLE, FETCH, EXEC, MEM_WAIT, HALT. Outputs are decoded from registered state (Moore), except pc_en/pc_load, which use the current dec_* inputs.
- IDLE: go to FETCH if run=1 or a step rising edge is detected (step registered once; edge = step & ~step_q).
- FETCH (1 cycle, phase=0): ir_en=1; pc_en=dec_pc_inc. Always go to EXEC.
- EXEC (phase=1):
  - If dec_halt: go to HALT; no PC strobes; instr_cnt += 1.
  - Else if (dec_ram_rd | dec_ram_wr) and RAM_WAIT>0: ram_cs=1, ram_we=dec_ram_wr, load wait counter with RAM_WAIT-1, go to MEM_WAIT; no PC strobes this cycle.
  - Else (completion): ram_cs/ram_we as decoded; pc_load=dec_pc_ld; pc_en=dec_pc_inc & ~dec_pc_ld; instr_cnt += 1; go to FETCH if run=1, otherwise IDLE.
- MEM_WAIT: ram_cs=1; ram_we latched from EXEC entry, held stable for the whole access. Counter decrements each cycle. On the cycle the counter reaches 0, perform the completion actions listed for EXEC, using the latched PC requests.
- HALT: all strobes 0; halted=1. Go to IDLE when halt_clr=1. run, step and the step edge register are ignored in HALT.
- pc_load and pc_en are never asserted in the same cycle; load wins.
- dec_ram_rd and dec_ram_wr both set: treat as a write.
- instr_cnt wraps from all-ones to 0.
- run deasserted mid-instruction: the instruction completes, then the block enters IDLE.
- A step edge while run=1 or while busy is ignored and not queued.
- reset asserted mid-MEM_WAIT: ram_cs/ram_we drop immediately (asynchronous).

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding localparams (IDLE=0, FETCH=1, EXEC=2, MEM_WAIT=3, HALT=4);
  - decode-word bit positions for pc_inc/pc_ld/ram_rd/ram_wr/halt;
  - PHASE_FETCH/PHASE_EXEC constants.
- One sub-module: seq_wait_timer, a 4-bit loadable down-counter with a zero flag, used for MEM_WAIT.

Test Plan:
- Reset held 0 for 3 cycles, run=1 -> all strobes 0, instr_cnt=0. After release: FETCH then EXEC alternate; ir_en high every 2nd cycle; instr_cnt=5 after 10 cycles.
- run=0, step pulsed once with dec_pc_inc=1 -> exactly one FETCH+EXEC, pc_en high for 2 cycles total, instr_cnt=1, back in IDLE; a second step while busy is ignored.
- RAM_WAIT=3, dec_ram_wr=1 in EXEC -> ram_cs=ram_we=1 for 4 consecutive cycles, PC strobe only on the last one, instr_cnt +1.
- dec_pc_ld=1 and dec_pc_inc=1 in EXEC -> pc_load=1, pc_en=0 that cycle.
- dec_halt=1 -> halted=1, no further FETCH despite run=1 or step edges; halt_clr=1 -> IDLE, then FETCH next cycle with run=1.
- instr_cnt preset near 16'hFFFF via 2 retirements -> wraps to 16'h0000 then 16'h0001.
